// File: rtl/side_store_pkg.sv
// Shared widths, side encoding and read-response payload for the side store.
package side_store_pkg;

  localparam int unsigned DATA_W = 7;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  localparam logic SIDE_LEFT  = 1'b0;
  localparam logic SIDE_RIGHT = 1'b1;

  typedef logic [DATA_W-1:0] word_t;

  // Registered read-port response
  typedef struct packed {
    logic  valid;
    logic  err;
    logic  side;
    word_t data;
  } rd_resp_t;

endpackage

// File: rtl/side_store_unit_fifo.sv
// side_fifo: single-clock circular FIFO for one side of the store.
//   clk, rst      : clock, synchronous active-high reset
//   wr_en/wr_data : push request and word
//   rd_en         : pop request (ignored when empty)
//   rd_data       : head entry (combinational from memory)
//   count         : occupancy 0..DEPTH
//   full/empty    : decoded from the registered count
module side_fifo
  import side_store_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic             rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic             full,
  output logic             empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_rd;
  logic              do_wr;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == CNT_W'(0));

  // A pop on a full FIFO frees the slot the same-cycle push lands in
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/side_store_unit.sv
// side_store_unit: captures the control unit's user word on each rising edge
// of en_left/en_right into per-side FIFOs and serves them on a 1-cycle
// request/valid read port.
//   clk, rst                  : clock, synchronous active-high reset
//   din, en_left, en_right    : word and level enables from the control unit
//   rd_req, rd_sel            : read request and side (0 left, 1 right)
//   rd_valid/rd_data/rd_side  : registered read response
//   rd_err                    : registered pulse, read of an empty side
//   left_/right_count,_full,_empty : per-side occupancy and status
//   overflow                  : sticky, a write to a full side was dropped
module side_store_unit
  import side_store_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              en_left,
  input  logic              en_right,
  input  logic              rd_req,
  input  logic              rd_sel,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_side,
  output logic              rd_err,
  output logic [CNT_W-1:0]  left_count,
  output logic [CNT_W-1:0]  right_count,
  output logic              left_full,
  output logic              right_full,
  output logic              left_empty,
  output logic              right_empty,
  output logic              overflow
);

  logic     en_left_q;
  logic     en_right_q;
  logic     wr_l;
  logic     wr_r;
  logic     rd_l;
  logic     rd_r;
  logic     drop;
  logic     sel_empty;
  word_t    left_head;
  word_t    right_head;
  word_t    sel_head;
  rd_resp_t resp_q;

  // Enables are levels; only the rising edge is a write
  assign wr_l = en_left  & ~en_left_q;
  assign wr_r = en_right & ~en_right_q;

  assign rd_l = rd_req & (rd_sel == SIDE_LEFT);
  assign rd_r = rd_req & (rd_sel == SIDE_RIGHT);

  side_fifo u_left (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_l),
    .wr_data (din),
    .rd_en   (rd_l),
    .rd_data (left_head),
    .count   (left_count),
    .full    (left_full),
    .empty   (left_empty)
  );

  side_fifo u_right (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_r),
    .wr_data (din),
    .rd_en   (rd_r),
    .rd_data (right_head),
    .count   (right_count),
    .full    (right_full),
    .empty   (right_empty)
  );

  // Read mux over the selected side's pre-cycle state
  assign sel_empty = (rd_sel == SIDE_RIGHT) ? right_empty : left_empty;
  assign sel_head  = (rd_sel == SIDE_RIGHT) ? right_head  : left_head;

  // A full side only drops the word when no same-side read frees a slot
  assign drop = (wr_l & left_full  & ~rd_l) |
                (wr_r & right_full & ~rd_r);

  // Edge-detect history, read response and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      en_left_q  <= 1'b0;
      en_right_q <= 1'b0;
      resp_q     <= '0;
      overflow   <= 1'b0;
    end else begin
      en_left_q    <= en_left;
      en_right_q   <= en_right;
      resp_q.valid <= rd_req & ~sel_empty;
      resp_q.err   <= rd_req &  sel_empty;
      if (rd_req) resp_q.side <= rd_sel;
      if (rd_req & ~sel_empty) resp_q.data <= sel_head;
      if (drop) overflow <= 1'b1;
    end
  end

  assign rd_valid = resp_q.valid;
  assign rd_err   = resp_q.err;
  assign rd_side  = resp_q.side;
  assign rd_data  = resp_q.data;

endmodule
